fp_add_seq: RTL and testbench

- Initiator-side sequencer for the pipelined FP32 adder's operand/result interface (op_1, op_2, en → res, val).
- Accepts a stream of IEEE-754 single-precision values over a valid/ready input and drives them one at a time into the adder.
- Feeds each adder result back as the next op_1, so the block performs a running-sum reduction of N terms.
- Reports the final sum with a done pulse. Adder latency is arbitrary; the sequencer waits for val and does not count cycles, except for the timeout guard.

---
 rtl/fp_add_seq.sv | 143 ++++++++++++++
 tb/tb_fp_add_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq.sv
// fp_add_seq: initiator-side sequencer for a pipelined FP32 adder.
// Accepts `len` FP32 terms one at a time and issues each to the adder.
// Each adder result becomes the next op_1, so the block forms a running sum.
// It reports the final sum with a one-cycle done pulse.
// No arithmetic is performed here; the accumulator is a bit-exact copy of
// whatever the adder returns.
//
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   start, len          : begin a reduction of `len` terms (sampled in IDLE)
//   in_data/valid/ready : term input handshake (in_ready registered)
//   add_op_1/op_2/en    : adder operands and issue strobe
//   add_res/val         : adder result and result-valid pulse
//   sum, done           : final sum (held) and completion pulse
//   busy, err           : not-idle flag and sticky timeout flag
module fp_add_seq #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      add_op_1,
  output logic [31:0]      add_op_2,
  output logic             add_en,
  input  logic [31:0]      add_res,
  input  logic             add_val,
  output logic [31:0]      sum,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    T_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0]    T_ONE    = {{(TW-1){1'b0}}, 1'b1};
  // Last WAIT cycle index; reaching it without add_val ends the wait.
  localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      acc_r;
  logic [TW-1:0]    tcnt_r;

  // Sequencer FSM, accumulator, counters and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= CNT_ZERO;
      acc_r    <= 32'h0000_0000;
      tcnt_r   <= T_ZERO;
      in_ready <= 1'b0;
      add_op_1 <= 32'h0000_0000;
      add_op_2 <= 32'h0000_0000;
      add_en   <= 1'b0;
      sum      <= 32'h0000_0000;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cnt_r <= len;
            acc_r <= 32'h0000_0000;
            err   <= 1'b0;
            busy  <= 1'b1;
            // A zero-length reduction never touches the counter or the adder.
            if (len == CNT_ZERO) begin
              state_r <= S_DONE;
            end else begin
              state_r  <= S_FETCH;
              in_ready <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_FETCH: begin
          // Operands are loaded here so they are valid during the ISSUE cycle.
          if (in_valid && in_ready) begin
            add_op_1 <= acc_r;
            add_op_2 <= in_data;
            add_en   <= 1'b1;
            in_ready <= 1'b0;
            state_r  <= S_ISSUE;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_ISSUE: begin
          add_en  <= 1'b0;
          tcnt_r  <= T_ZERO;
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          // add_val takes priority over a timeout in the same cycle.
          if (add_val) begin
            acc_r <= add_res;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= S_DONE;
            end else begin
              state_r  <= S_FETCH;
              in_ready <= 1'b1;
            end
          end else if (tcnt_r == T_LAST) begin
            err     <= 1'b1;
            state_r <= S_DONE;
          end else begin
            tcnt_r <= tcnt_r + T_ONE;
          end
        end
        S_DONE: begin
          sum     <= acc_r;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          in_ready <= 1'b0;
          add_en   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed testbench for fp_add_seq with a table-driven adder model of
// configurable latency.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [31:0] in_data = 32'h0000_0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] add_op_1;
  logic [31:0] add_op_2;
  logic        add_en;
  logic [31:0] add_res;
  logic        add_val;
  logic [31:0] sum;
  logic        done;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Adder model state.
  int          lat = 2;
  logic        model_on = 1'b1;
  int          m_timer = 0;
  logic        m_val = 1'b0;
  logic [31:0] m_res = 32'h0000_0000;
  logic        inj_val = 1'b0;

  // Monitors.
  int          en_count = 0;
  int          done_count = 0;
  logic [31:0] iss_op1 [0:7];
  logic [31:0] iss_op2 [0:7];

  assign add_val = m_val | inj_val;
  assign add_res = inj_val ? 32'h7F7F_7F7F : m_res;

  fp_add_seq #(.CNT_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_op_1(add_op_1), .add_op_2(add_op_2), .add_en(add_en),
    .add_res(add_res), .add_val(add_val),
    .sum(sum), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Hand-computed FP32 sums for the vectors used here; anything else is poison.
  function automatic logic [31:0] fp_tbl(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] k;
    k = {a, b};
    case (k)
      {32'h0000_0000, 32'h3F80_0000}: fp_tbl = 32'h3F80_0000;
      {32'h3F80_0000, 32'h4000_0000}: fp_tbl = 32'h4040_0000;
      {32'h4040_0000, 32'h4040_0000}: fp_tbl = 32'h40C0_0000;
      {32'h0000_0000, 32'h40A0_0000}: fp_tbl = 32'h40A0_0000;
      {32'h40A0_0000, 32'hC0A0_0000}: fp_tbl = 32'h0000_0000;
      default:                        fp_tbl = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Adder model: result valid pulses `lat` cycles after the issue edge.
  always @(posedge clk) begin
    m_val <= 1'b0;
    if (add_en && model_on) begin
      m_res <= fp_tbl(add_op_1, add_op_2);
      if (lat == 1) m_val <= 1'b1;
      else m_timer <= lat - 1;
    end else if (m_timer != 0) begin
      m_timer <= m_timer - 1;
      if (m_timer == 1) m_val <= 1'b1;
    end
  end

  // Issue and completion monitors.
  always @(posedge clk) begin
    if (add_en) begin
      if (en_count < 8) begin
        iss_op1[en_count] <= add_op_1;
        iss_op2[en_count] <= add_op_2;
      end
      en_count <= en_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("feed_ready_seen", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int en_base;
    int dn_base;
    int stable;

    // ---- Reset state ----
    #12;
    chk("reset_outputs", {29'd0, in_ready, add_en, done}, 32'd0);
    chk("reset_flags", {30'd0, busy, err}, 32'd0);
    chk("reset_sum", sum, 32'h0000_0000);
    chk("reset_op1", add_op_1, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;
    step();

    // ---- Sum of three terms, L=2 ----
    lat = 2;
    en_base = en_count;
    dn_base = done_count;
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    chk("t1_fetch_ready", {30'd0, in_ready, busy}, 32'd3);
    feed(32'h3F80_0000);
    feed(32'h4000_0000);
    feed(32'h4040_0000);
    wait_done(100);
    chk("t1_sum", sum, 32'h40C0_0000);
    chk("t1_err", {31'd0, err}, 32'd0);
    step(); step();
    chk("t1_en_count", en_count - en_base, 32'd3);
    chk("t1_iss2_op1", iss_op1[en_base + 1], 32'h3F80_0000);
    chk("t1_iss2_op2", iss_op2[en_base + 1], 32'h4000_0000);
    chk("t1_done_count", done_count - dn_base, 32'd1);

    // ---- Zero length ----
    en_base = en_count;
    chk("t2_sum_held", sum, 32'h40C0_0000);
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    chk("t2_done_early", {31'd0, done}, 32'd0);
    step();
    chk("t2_done_2cyc", {31'd0, done}, 32'd1);
    chk("t2_sum", sum, 32'h0000_0000);
    chk("t2_no_en", en_count - en_base, 32'd0);

    // ---- Backpressure, L=5, spurious inputs ----
    step();
    lat = 5;
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (in_ready === 1'b1) stable++;
    end
    chk("t3_ready_held", stable, 32'd10);
    feed(32'h40A0_0000);
    chk("t3_issue", {add_en, add_op_1[30:0]}, 32'h8000_0000);
    chk("t3_issue_op2", add_op_2, 32'h40A0_0000);
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (add_en === 1'b0 && add_op_1 === 32'h0 && add_op_2 === 32'h40A0_0000) stable++;
    end
    chk("t3_ops_stable", stable, 32'd5);
    step();
    chk("t3_back_in_fetch", {31'd0, in_ready}, 32'd1);
    inj_val = 1'b1;              // spurious result during FETCH
    start = 1'b1; len = 8'd1;    // start while busy must be ignored
    step();
    inj_val = 1'b0;
    start = 1'b0;
    feed(32'hC0A0_0000);
    wait_done(100);
    chk("t3_sum", sum, 32'h0000_0000);
    chk("t3_err", {31'd0, err}, 32'd0);
    step();
    inj_val = 1'b1;              // spurious result during IDLE
    step();
    inj_val = 1'b0;
    step();
    chk("t3_idle_val_ignored", {30'd0, busy, done}, 32'd0);

    // ---- Timeout ----
    model_on = 1'b0;
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    feed(32'h3F80_0000);        // now in ISSUE
    for (int i = 0; i < 64; i++) step();
    chk("t4_before_timeout", {29'd0, busy, err, done}, 32'd4);
    step();
    chk("t4_err_set", {30'd0, err, done}, 32'd2);
    step();
    chk("t4_done", {30'd0, err, done}, 32'd3);
    chk("t4_sum", sum, 32'h0000_0000);
    model_on = 1'b1;
    lat = 1;
    step();
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    feed(32'h3F80_0000);
    wait_done(100);
    chk("t4_good_sum", sum, 32'h3F80_0000);

    // ---- Reset mid-WAIT ----
    step();
    lat = 5;
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    feed(32'h40A0_0000);
    step(); step();             // in WAIT, result still pending
    #2;
    reset = 1'b1;
    #1;
    chk("t5_reset_ctrl", {27'd0, in_ready, add_en, done, busy, err}, 32'd0);
    chk("t5_reset_sum", sum, 32'h0000_0000);
    chk("t5_reset_ops", add_op_1 | add_op_2, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();   // late add_val arrives here
    chk("t5_late_val_ignored", {31'd0, busy}, 32'd0);
    chk("t5_sum_after_late", sum, 32'h0000_0000);
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    feed(32'h3F80_0000);
    wait_done(100);
    chk("t5_fresh_sum", sum, 32'h3F80_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
